// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// exec_unit : execute stage, 1-cycle ALU ops plus iterative mul/div/mod
// Revision  : 1.0
// ============================================================================
module exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5,
  parameter int SIDE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [SIDE_WIDTH-1:0] in_side,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [SIDE_WIDTH-1:0] out_side,
  output logic                  busy
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_NOR   = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_MULH  = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_MOD   = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_MODU  = OP_WIDTH'(17);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [OP_WIDTH-1:0]     op_q;
  logic [DATA_WIDTH-1:0]   src1_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic                    neg_q;
  logic                    rneg_q;
  logic                    div0_q;
  logic [SIDE_WIDTH-1:0]   side_q;

  logic                    accept;
  logic                    in_iter;
  logic                    in_signed;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   b_mag;
  logic [SHW-1:0]          shamt;
  logic [DATA_WIDTH-1:0]   alu_res;

  logic                    is_div_q;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_sh;
  logic [DATA_WIDTH:0]     div_diff;
  logic [DATA_WIDTH-1:0]   acc_d;
  logic [DATA_WIDTH-1:0]   lo_d;
  logic [DATA_WIDTH-1:0]   mulh_hi;
  logic [DATA_WIDTH-1:0]   done_res;

  assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);

  // Single-cycle datapath and operand preparation for iterative ops
  always_comb begin
    shamt     = in_src2[SHW-1:0];
    in_iter   = (in_op >= OP_MUL) && (in_op <= OP_MODU);
    in_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_MOD);
    a_neg     = in_signed && in_src1[DATA_WIDTH-1];
    b_neg     = in_signed && in_src2[DATA_WIDTH-1];
    a_mag     = a_neg ? -in_src1 : in_src1;
    b_mag     = b_neg ? -in_src2 : in_src2;
    alu_res   = '0;
    case (in_op)
      OP_ADD:  alu_res = in_src1 + in_src2;
      OP_SUB:  alu_res = in_src1 - in_src2;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (in_src1 < in_src2)};
      OP_AND:  alu_res = in_src1 & in_src2;
      OP_OR:   alu_res = in_src1 | in_src2;
      OP_XOR:  alu_res = in_src1 ^ in_src2;
      OP_NOR:  alu_res = ~(in_src1 | in_src2);
      OP_SLL:  alu_res = in_src1 << shamt;
      OP_SRL:  alu_res = in_src1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_src1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // acc/lo hold {product high, multiplier/product low} or {remainder, dividend/quotient}
  always_comb begin
    is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_MOD) || (op_q == OP_MODU);
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q, lo_q[DATA_WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (is_div_q) begin
      acc_d = div_diff[DATA_WIDTH] ? div_sh[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
      lo_d  = {lo_q[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH]};
    end else begin
      acc_d = mul_sum[DATA_WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  // High half of a negated 2W product: ~hi plus the carry out of -lo
  always_comb begin
    mulh_hi  = neg_q ? (~acc_q + {{(DATA_WIDTH-1){1'b0}}, (lo_q == '0)}) : acc_q;
    done_res = '0;
    case (op_q)
      OP_MUL:   done_res = lo_q;
      OP_MULH:  done_res = mulh_hi;
      OP_MULHU: done_res = acc_q;
      OP_DIV,
      OP_DIVU:  done_res = div0_q ? '1 : (neg_q ? -lo_q : lo_q);
      OP_MOD,
      OP_MODU:  done_res = div0_q ? src1_q : (rneg_q ? -acc_q : acc_q);
      default:  done_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      src1_q     <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      div0_q     <= 1'b0;
      side_q     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_side   <= '0;
    end else if (flush) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (in_iter) begin
              op_q    <= in_op;
              src1_q  <= in_src1;
              b_q     <= b_mag;
              lo_q    <= a_mag;
              acc_q   <= '0;
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              div0_q  <= (in_src2 == '0);
              side_q  <= in_side;
              cnt_q   <= CW'(DATA_WIDTH);
              state_q <= S_CALC;
            end else begin
              out_valid  <= 1'b1;
              out_result <= alu_res;
              out_side   <= in_side;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!out_valid || out_ready) begin
            out_valid  <= 1'b1;
            out_result <= done_res;
            out_side   <= side_q;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
